// File: rtl/fir_decim_out.sv
// Decimating output stage for the FIR: accumulate-and-dump over DECIM samples,
// round/scale/saturate to OUT_W, and buffer results in a small valid/ready FIFO.
module fir_decim_out #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 8,
  parameter int DECIM      = 4,
  parameter int SHIFT      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            in_valid,
  input  logic signed [IN_W-1:0]          in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [OUT_W-1:0]         out_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            sat_flag,
  output logic                            overflow
);
  localparam int AW = IN_W + $clog2(DECIM);
  localparam int PW = $clog2(DECIM);
  localparam int LW = $clog2(FIFO_DEPTH);

  localparam logic signed [AW:0]      HALF = (AW+1)'(1) << (SHIFT-1);
  localparam logic signed [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [AW:0]      RMAX = {{(AW+1-OUT_W){1'b0}}, OMAX};
  localparam logic signed [AW:0]      RMIN = {{(AW+1-OUT_W){1'b1}}, OMIN};

  logic [PW-1:0]             phase_q, phase_d;
  logic signed [AW-1:0]      acc_q, acc_d;
  logic signed [OUT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [LW-1:0]             wr_q, wr_d, rd_q, rd_d;
  logic [LW:0]               cnt_q, cnt_d;
  logic signed [OUT_W-1:0]   dout_q, dout_d;
  logic                      sat_q, sat_d, ovf_q, ovf_d;

  logic signed [AW-1:0]      sum;
  logic signed [AW:0]        rnd, r;
  logic signed [OUT_W-1:0]   res;
  logic                      push, pop, full, wr_en, sat_hi, sat_lo;

  // One extra bit on the rounding path so adding HALF can never wrap.
  assign sum    = acc_q + {{(AW-IN_W){in_data[IN_W-1]}}, in_data};
  assign rnd    = {sum[AW-1], sum} + HALF;
  assign r      = rnd >>> SHIFT;
  assign sat_hi = (r > RMAX);
  assign sat_lo = (r < RMIN);
  assign res    = sat_hi ? OMAX : (sat_lo ? OMIN : $signed(r[OUT_W-1:0]));

  assign push  = in_valid && (phase_q == PW'(DECIM-1));
  assign full  = (cnt_q == (LW+1)'(FIFO_DEPTH));
  assign pop   = (cnt_q != '0) && out_ready;
  assign wr_en = push && (!full || pop);

  always_comb begin
    phase_d = phase_q;
    acc_d   = acc_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q + (LW+1)'(wr_en) - (LW+1)'(pop);
    dout_d  = dout_q;
    sat_d   = sat_q;
    ovf_d   = ovf_q;
    if (in_valid) begin
      if (push) begin
        phase_d = '0;
        acc_d   = '0;
        sat_d   = sat_q | sat_hi | sat_lo;
        ovf_d   = ovf_q | (full && !pop);
      end else begin
        phase_d = phase_q + PW'(1);
        acc_d   = sum;
      end
    end
    if (wr_en) wr_d = wr_q + LW'(1);
    if (pop)   rd_d = rd_q + LW'(1);
    // The head register follows the next live entry; when empty it keeps its last value.
    if (pop) begin
      if (cnt_q > (LW+1)'(1)) dout_d = mem_q[rd_q + LW'(1)];
      else if (wr_en)         dout_d = res;
    end else if ((cnt_q == '0) && wr_en) begin
      dout_d = res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      acc_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (clear) begin
      phase_q <= '0;
      acc_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      acc_q   <= acc_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
      if (wr_en) mem_q[wr_q] <= res;
    end
  end

  assign out_valid  = (cnt_q != '0);
  assign out_data   = dout_q;
  assign fifo_level = cnt_q;
  assign sat_flag   = sat_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_fir_decim_out.sv
// Directed bench for fir_decim_out: hand-computed vectors for dump, rounding,
// saturation, gapped input, FIFO backpressure/overflow and reset/clear.
module tb_fir_decim_out;
  logic               clk = 1'b0;
  logic               rst, clear, in_valid, out_ready;
  logic signed [15:0] in_data;
  logic               out_valid, sat_flag, overflow;
  logic signed [7:0]  out_data;
  logic [2:0]         fifo_level;
  int                 total = 0;
  int                 bad   = 0;
  int                 nout;

  fir_decim_out dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_level(fifo_level), .sat_flag(sat_flag), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = 16'(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send4(input int v);
    for (int i = 0; i < 4; i++) send(v);
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    tick();

    // basic dump
    send(10); send(20); send(30);
    chk("basic_early", out_valid, 0);
    send(40);
    chk("basic_valid", out_valid, 1);
    chk("basic_data", out_data, 25);
    chk("basic_level", fifo_level, 1);
    tick();
    chk("basic_pulse", out_valid, 0);
    chk("basic_hold", out_data, 25);
    chk("basic_sat", sat_flag, 0);

    // negative rounding
    send4(-3);
    chk("neg3_data", out_data, -3);
    tick();
    send(-1); send(-1); send(0); send(0);
    chk("neg_half_valid", out_valid, 1);
    chk("neg_half_data", out_data, 0);
    tick();

    // saturation
    send4(1000);
    chk("satp_data", out_data, 127);
    chk("satp_flag", sat_flag, 1);
    tick();
    send4(-1000);
    chk("satn_data", out_data, -128);
    chk("satn_flag", sat_flag, 1);
    tick();

    // gapped input: one sample every third cycle
    nout = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 16'sd4;
      tick();
      in_valid = 1'b0;
      if (out_valid) begin
        nout++;
        chk("gap_data", out_data, 4);
      end
      tick(); tick();
    end
    chk("gap_count", nout, 2);
    chk("gap_empty", out_valid, 0);

    // backpressure and overflow
    out_ready = 1'b0;
    for (int g = 1; g <= 4; g++) send4(4 * g);
    chk("bp_level4", fifo_level, 4);
    chk("bp_head", out_data, 4);
    chk("bp_noovf", overflow, 0);
    send4(20);
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, 4 * k);
      tick();
    end
    chk("drain_empty", out_valid, 0);
    chk("drain_level", fifo_level, 0);

    // clear, then push and pop together at full
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_ovf", overflow, 0);
    chk("clr_sat", sat_flag, 0);
    chk("clr_data", out_data, 0);
    out_ready = 1'b0;
    for (int g = 1; g <= 4; g++) send4(4 * g);
    send(20); send(20); send(20);
    out_ready = 1'b1;
    send(20);
    chk("pp_level", fifo_level, 4);
    chk("pp_noovf", overflow, 0);
    chk("pp_head", out_data, 8);
    for (int k = 2; k <= 5; k++) begin
      chk("pp_drain", out_data, 4 * k);
      tick();
    end
    chk("pp_empty", out_valid, 0);

    // asynchronous reset mid-group discards the partial sum
    send4(1000);
    tick();
    send(100); send(100);
    #2 rst = 1'b1;
    #1;
    chk("arst_data", out_data, 0);
    chk("arst_sat", sat_flag, 0);
    chk("arst_level", fifo_level, 0);
    rst = 1'b0;
    tick();
    send4(8);
    chk("arst_next", out_data, 8);
    tick();

    // synchronous clear mid-group
    send4(1000);
    tick();
    chk("pre_clr_sat", sat_flag, 1);
    send(100); send(100);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("sclr_data", out_data, 0);
    chk("sclr_sat", sat_flag, 0);
    send4(8);
    chk("sclr_next", out_data, 8);
    chk("sclr_valid", out_valid, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_decim_out.md
Name: fir_decim_out

Overview:
Output stage directly downstream of the 4-tap FIR filter. It consumes the filter's 16-bit signed result stream and decimates it by accumulate-and-dump over DECIM samples. Each dump is rounded, scaled and saturated to an 8-bit signed word, then buffered in a small FIFO for a valid/ready consumer such as a DAC or serializer interface. The FIR output has no backpressure, so buffer overrun is flagged, never stalled.

Parameters:
IN_W, 16, input sample width (signed); matches FIR y_out.
OUT_W, 8, output sample width (signed).
DECIM, 4, decimation ratio; must be >= 2.
SHIFT, 2, right-shift applied to the dumped sum; must be >= 1.
FIFO_DEPTH, 4, output FIFO entries; must be a power of 2, >= 2.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
clear  input  1  synchronous clear: phase, accumulator, FIFO and sticky flags.
in_valid  input  1  in_data holds a new FIR sample this cycle.
in_data  input  IN_W  signed FIR output sample.
out_valid  output  1  FIFO non-empty; out_data is valid.
out_ready  input  1  consumer accepts out_data this cycle.
out_data  output  OUT_W  signed decimated sample at the FIFO head.
fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
sat_flag  output  1  sticky; set when any result saturated.
overflow  output  1  sticky; set when a result was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1, asynchronous): phase=0, acc=0, FIFO empty, out_valid=0, out_data=0, fifo_level=0, sat_flag=0, overflow=0. Reset mid-accumulation discards the partial sum.
- clear=1 at a clock edge has the same effect as reset and takes priority over in_valid and out_ready in that cycle.
- The accumulator is signed, IN_W+clog2(DECIM) bits wide, and cannot wrap.
- The phase counter runs 0..DECIM-1 and advances only on in_valid. Cycles with in_valid=0 hold all state.
- in_valid with phase < DECIM-1: acc <= acc + in_data; phase increments.
- in_valid with phase == DECIM-1 (dump):
  - sum = acc + in_data (full width);
  - r = (sum + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, i.e. round half toward +inf;
  - if r > 2^(OUT_W-1)-1, the result is 2^(OUT_W-1)-1; if r < -2^(OUT_W-1), the result is -2^(OUT_W-1); either case sets sat_flag;
  - the result is pushed into the FIFO at the same edge; acc <= 0; phase <= 0.
- Latency: out_valid rises the cycle after the edge that captured the final sample of a group, when the FIFO was empty.
- FIFO behaviour:
  - out_data shows the head entry and is registered/stable while out_valid=1 and out_ready=0;
  - pop happens when out_valid and out_ready are both 1 at an edge;
  - when empty, out_data holds its last value and out_valid=0.
- Push while full with no pop in the same cycle: the new result is dropped, overflow is set, and FIFO contents are unchanged.
- Push and pop in the same cycle while full: both happen, no drop, fifo_level unchanged.
- Push and pop in the same cycle while empty: not possible, since out_valid=0.
- fifo_level is exact every cycle, range 0..FIFO_DEPTH.
- Sticky flags clear only on rst or clear.

Test Plan:
- Basic dump (DECIM=4, SHIFT=2, out_ready=1): in 10,20,30,40 -> sum 100, (100+2)>>>2 = 25; out_valid pulses 1 cycle with out_data=25; sat_flag=0.
- Negative rounding: in -3,-3,-3,-3 -> sum -12, (-12+2)>>>2 = -3; in -1,-1,0,0 -> sum -2, (0)>>>2 = 0.
- Saturation: in 1000×4 -> out_data=127, sat_flag=1; in -1000×4 -> out_data=-128; sat_flag stays 1 until clear.
- Gapped input: in_valid asserted every 3rd cycle for 8 samples of value 4 -> exactly 2 outputs of (16+2)>>>2 = 4; idle cycles do not advance phase.
- Overflow and backpressure: out_ready=0 for 5 groups -> fifo_level=4, 5th group dropped, overflow=1; release out_ready -> 4 words pop in order, then out_valid=0. At full, push+pop in the same cycle -> level stays 4, overflow not newly set.
- Reset/clear mid-operation: assert rst after 2 of 4 samples -> all outputs 0. The next 4 samples of 8 give out_data=8, confirming the partial sum was discarded. Repeat with clear -> same result; sticky flags cleared.
